// File: rtl/sram_confreg_if.sv
// sram_confreg_if: data-SRAM style request bus (en/we/addr/wdata, registered rdata)
interface sram_confreg_if;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    modport master (output en, we, addr, wdata, input rdata);
    modport slave (input en, we, addr, wdata, output rdata);
endinterface

// File: rtl/sram_confreg.sv
// sram_confreg: memory-mapped LED/switch/timer/scratch registers on the data SRAM port
module sram_confreg #(
    parameter logic [31:0] BASE_ADDR = 32'hbfaf_0000,
    parameter int          SW_W      = 8
) (
    input  logic            clk,
    input  logic            reset,
    sram_confreg_if.slave   bus,
    output logic [15:0]     led,
    input  logic [SW_W-1:0] sw,
    output logic            timer_irq
);
    logic [31:0]     rdata_q, rdata_d, timer_q, timer_d, cmp_q, cmp_d, scratch_q, scratch_d;
    logic [15:0]     led_q, led_d;
    logic [SW_W-1:0] sw1_q, sw2_q;
    logic [1:0]      ctrl_q, ctrl_d;
    logic            match_q, match_d, irq_q;
    logic            hit, wr;
    logic [13:0]     word;
    logic [31:0]     mask, sw_ext, rd_val;

    assign hit    = bus.en && (bus.addr[31:16] == BASE_ADDR[31:16]);
    assign wr     = hit && (bus.we != 4'b0);
    assign word   = bus.addr[15:2];
    assign mask   = {{8{bus.we[3]}}, {8{bus.we[2]}}, {8{bus.we[1]}}, {8{bus.we[0]}}};
    assign sw_ext = 32'(sw2_q);

    // read mux and next-state for every register; reads see pre-edge values
    always_comb begin
        rd_val    = word == 14'd0 ? {16'h0, led_q} :
                    word == 14'd1 ? sw_ext :
                    word == 14'd2 ? timer_q :
                    word == 14'd3 ? cmp_q :
                    word == 14'd4 ? {30'h0, ctrl_q} :
                    word == 14'd5 ? {31'h0, match_q} :
                    word == 14'd6 ? scratch_q : 32'h0;
        rdata_d   = hit ? rd_val : (bus.en ? 32'h0 : rdata_q);
        led_d     = (wr && word == 14'd0) ? (led_q & ~mask[15:0]) | (bus.wdata[15:0] & mask[15:0]) : led_q;
        timer_d   = (wr && word == 14'd2) ? (timer_q & ~mask) | (bus.wdata & mask) :
                    ctrl_q[0] ? timer_q + 32'd1 : timer_q;
        cmp_d     = (wr && word == 14'd3) ? (cmp_q & ~mask) | (bus.wdata & mask) : cmp_q;
        ctrl_d    = (wr && word == 14'd4 && bus.we[0]) ? bus.wdata[1:0] : ctrl_q;
        scratch_d = (wr && word == 14'd6) ? (scratch_q & ~mask) | (bus.wdata & mask) : scratch_q;
        match_d   = (ctrl_q[0] && timer_q == cmp_q) ||
                    (match_q && !(wr && word == 14'd5 && bus.we[0] && bus.wdata[0]));
    end

    // state registers, all cleared by the asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q   <= '0;
            led_q     <= '0;
            sw1_q     <= '0;
            sw2_q     <= '0;
            timer_q   <= '0;
            cmp_q     <= '0;
            ctrl_q    <= '0;
            match_q   <= 1'b0;
            irq_q     <= 1'b0;
            scratch_q <= '0;
        end else begin
            rdata_q   <= rdata_d;
            led_q     <= led_d;
            sw1_q     <= sw;
            sw2_q     <= sw1_q;
            timer_q   <= timer_d;
            cmp_q     <= cmp_d;
            ctrl_q    <= ctrl_d;
            match_q   <= match_d;
            irq_q     <= match_q & ctrl_q[1];
            scratch_q <= scratch_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign led       = led_q;
    assign timer_irq = irq_q;
endmodule

// File: tb/tb_sram_confreg.sv
// tb_sram_confreg: scoreboard bench for the configuration register block
module tb_sram_confreg;
    localparam logic [31:0] B = 32'hbfaf_0000;
    typedef struct {
        string       name;
        logic [31:0] v;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  sw = 8'h00;
    logic [15:0] led;
    logic        timer_irq;
    int          total = 0;
    int          passed = 0;
    exp_t        sb[$];
    logic [31:0] obs[$];

    sram_confreg_if bus();
    sram_confreg #(.BASE_ADDR(B), .SW_W(8)) dut (
        .clk(clk), .reset(reset), .bus(bus), .led(led), .sw(sw), .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    task automatic op(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                      input bit chk, input logic [31:0] e, input string n);
        bus.en = 1'b1;
        bus.we = w;
        bus.addr = a;
        bus.wdata = d;
        if (chk) sb.push_back('{n, e});
        @(posedge clk);
        #1;
        if (chk) obs.push_back(bus.rdata);
        bus.en = 1'b0;
        bus.we = 4'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [31:0] o;
        do_reset();
        for (int i = 0; i < 7; i++) op(4'h0, B + 32'(i * 4), 32'h0, 1'b1, 32'h0, "reset_read");
        total++;
        if (led !== 16'h0) $display("FAIL reset_led: got %h expected 0000", led); else passed++;
        total++;
        if (timer_irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", timer_irq); else passed++;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs.pop_front();
            total++;
            if (o !== e.v) $display("FAIL %s: rdata=%h expected %h", e.name, o, e.v); else passed++;
        end
    endtask

    task automatic test_led();
        exp_t e;
        logic [31:0] o;
        op(4'b0011, B, 32'h1234abcd, 1'b1, 32'h0, "led_wr_old");
        total++;
        if (led !== 16'habcd) $display("FAIL led_out1: got %h expected abcd", led); else passed++;
        op(4'h0, B, 32'h0, 1'b1, 32'h0000abcd, "led_rd1");
        op(4'b0001, B, 32'h000000ff, 1'b0, 32'h0, "");
        total++;
        if (led !== 16'habff) $display("FAIL led_out2: got %h expected abff", led); else passed++;
        op(4'h0, B, 32'h0, 1'b1, 32'h0000abff, "led_rd2");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs.pop_front();
            total++;
            if (o !== e.v) $display("FAIL %s: rdata=%h expected %h", e.name, o, e.v); else passed++;
        end
    endtask

    task automatic test_timer();
        exp_t e;
        logic [31:0] o;
        op(4'hf, B + 32'h8, 32'hffff_fffe, 1'b1, 32'h0, "timer_wr_old");
        op(4'hf, B + 32'h10, 32'h1, 1'b1, 32'h0, "ctrl_wr_old");
        op(4'h0, B + 32'h8, 32'h0, 1'b1, 32'hffff_fffe, "timer_seq0");
        op(4'h0, B + 32'h8, 32'h0, 1'b1, 32'hffff_ffff, "timer_seq1");
        op(4'h0, B + 32'h8, 32'h0, 1'b1, 32'h0, "timer_wrap");
        op(4'h0, B + 32'h8, 32'h0, 1'b1, 32'h1, "timer_seq3");
        op(4'hf, B + 32'h8, 32'h5, 1'b1, 32'h2, "timer_wr5_old");
        op(4'h0, B + 32'h8, 32'h0, 1'b1, 32'h5, "timer_after_wr");
        op(4'hf, B + 32'h10, 32'h0, 1'b1, 32'h1, "ctrl_off_old");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs.pop_front();
            total++;
            if (o !== e.v) $display("FAIL %s: rdata=%h expected %h", e.name, o, e.v); else passed++;
        end
    endtask

    task automatic test_match();
        exp_t e;
        logic [31:0] o;
        do_reset();
        op(4'hf, B + 32'hc, 32'd10, 1'b0, 32'h0, "");
        op(4'hf, B + 32'h8, 32'd0, 1'b0, 32'h0, "");
        op(4'hf, B + 32'h10, 32'd3, 1'b0, 32'h0, "");
        for (int k = 1; k <= 12; k++) begin
            op(4'h0, B + 32'h14, 32'h0, 1'b1, (k == 12) ? 32'h1 : 32'h0, "match_poll");
            total++;
            if (timer_irq !== (k >= 12)) $display("FAIL irq_k%0d: got %b expected %b", k, timer_irq, k >= 12);
            else passed++;
        end
        op(4'b0001, B + 32'h14, 32'h1, 1'b1, 32'h1, "w1c_old");
        op(4'h0, B + 32'h14, 32'h0, 1'b1, 32'h0, "match_cleared");
        total++;
        if (timer_irq !== 1'b0) $display("FAIL irq_cleared: got %b expected 0", timer_irq); else passed++;
        op(4'hf, B + 32'h8, 32'd8, 1'b0, 32'h0, "");
        op(4'h0, B + 32'h14, 32'h0, 1'b1, 32'h0, "pre_match0");
        op(4'h0, B + 32'h14, 32'h0, 1'b1, 32'h0, "pre_match1");
        op(4'b0001, B + 32'h14, 32'h1, 1'b1, 32'h0, "w1c_at_match_old");
        op(4'h0, B + 32'h14, 32'h0, 1'b1, 32'h1, "set_wins");
        op(4'hf, B + 32'h10, 32'h0, 1'b0, 32'h0, "");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs.pop_front();
            total++;
            if (o !== e.v) $display("FAIL %s: rdata=%h expected %h", e.name, o, e.v); else passed++;
        end
    endtask

    task automatic test_switch();
        exp_t e;
        logic [31:0] o;
        sw = 8'ha5;
        op(4'h0, B + 32'h4, 32'h0, 1'b1, 32'h0, "sw_sync0");
        op(4'h0, B + 32'h4, 32'h0, 1'b1, 32'h0, "sw_sync1");
        op(4'h0, B + 32'h4, 32'h0, 1'b1, 32'ha5, "sw_visible");
        op(4'hf, B + 32'h4, 32'h0, 1'b1, 32'ha5, "sw_wr_old");
        op(4'h0, B + 32'h4, 32'h0, 1'b1, 32'ha5, "sw_ro");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs.pop_front();
            total++;
            if (o !== e.v) $display("FAIL %s: rdata=%h expected %h", e.name, o, e.v); else passed++;
        end
    endtask

    task automatic test_read_first();
        exp_t e;
        logic [31:0] o;
        op(4'hf, B + 32'h18, 32'hdead_beef, 1'b1, 32'h0, "scratch_wr_old");
        op(4'h0, B + 32'h18, 32'h0, 1'b1, 32'hdead_beef, "scratch_rd");
        op(4'hf, 32'hbfb0_0018, 32'h1111_1111, 1'b1, 32'h0, "outside_wr");
        op(4'h0, 32'hbfb0_0018, 32'h0, 1'b1, 32'h0, "outside_rd");
        op(4'h0, B + 32'h18, 32'h0, 1'b1, 32'hdead_beef, "scratch_kept");
        op(4'h0, B + 32'h1c, 32'h0, 1'b1, 32'h0, "unmapped_rd");
        op(4'h0, B + 32'h18, 32'h0, 1'b1, 32'hdead_beef, "scratch_rd2");
        op(4'h0, B + 32'h0, 32'h0, 1'b0, 32'h0, "");
        total++;
        if (bus.rdata !== 32'h0000abff) $display("FAIL led_back2back: rdata=%h expected 0000abff", bus.rdata);
        else passed++;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs.pop_front();
            total++;
            if (o !== e.v) $display("FAIL %s: rdata=%h expected %h", e.name, o, e.v); else passed++;
        end
    endtask

    task automatic test_reset_mid_read();
        op(4'h0, B + 32'h18, 32'h0, 1'b0, 32'h0, "");
        total++;
        if (bus.rdata !== 32'hdead_beef) $display("FAIL pre_reset_rd: rdata=%h expected deadbeef", bus.rdata);
        else passed++;
        bus.en = 1'b1;
        bus.we = 4'h0;
        bus.addr = B + 32'h18;
        reset = 1'b1;
        #1;
        total++;
        if (bus.rdata !== 32'h0) $display("FAIL async_reset_rd: rdata=%h expected 0", bus.rdata); else passed++;
        @(posedge clk);
        #1;
        total++;
        if (bus.rdata !== 32'h0) $display("FAIL inflight_rd: rdata=%h expected 0", bus.rdata); else passed++;
        total++;
        if (led !== 16'h0) $display("FAIL reset_mid_led: got %h expected 0000", led); else passed++;
        bus.en = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        bus.en = 1'b0;
        bus.we = 4'h0;
        bus.addr = 32'h0;
        bus.wdata = 32'h0;
        test_reset();
        test_led();
        test_timer();
        test_match();
        test_switch();
        op(4'b0011, B, 32'h0000abff, 1'b0, 32'h0, "");
        test_read_first();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sram_confreg.md
# sram_confreg

Memory-mapped configuration-register responder for the CPU data SRAM port. It answers the same en/we/addr/wdata/rdata request interface that the data RAM answers, with the same one-cycle read latency. It provides LEDs, a synchronized switch input, a 32-bit timer with compare, and a scratch register. It sits beside the data RAM in the SoC top; the address decode that steers requests between the two lives outside this block.

## Interface
Parameters:
- BASE_ADDR, 32'hbfaf_0000: window base; a request hits when addr[31:16] == BASE_ADDR[31:16].
- SW_W, 8: switch input width.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- en  in  1  request valid this cycle.
- we  in  4  byte write enables; nonzero = write, zero = read.
- addr  in  32  byte address; bits [1:0] ignored.
- wdata  in  32  write data, lanes selected by we.
- rdata  out  32  read data, registered.
- led  out  16  LED register value.
- sw  in  SW_W  asynchronous switch inputs.
- timer_irq  out  1  STATUS.match & CTRL.irq_en, registered.

## Operation
Register map (offset = addr[15:0]). Registers are written per byte lane as we[i] gates bits [8i+7:8i].
- 0x00 LED: RW, bits [15:0]; upper bits read 0.
- 0x04 SWITCH: RO; two-flop synchronized sw, zero-extended; writes ignored.
- 0x08 TIMER: RW 32-bit. While CTRL.en=1 it increments by 1 per cycle and wraps 0xffffffff -> 0. A write in the same cycle overrides the increment with the byte-merged value, applied to the pre-increment register value.
- 0x0C TIMER_CMP: RW 32-bit.
- 0x10 CTRL: RW; bit0 en, bit1 irq_en; other bits read 0.
- 0x14 STATUS: bit0 match, sticky. It sets in any cycle where CTRL.en=1 and TIMER == TIMER_CMP, using the register values at that edge. Writing 1 to bit0 (we[0]=1) clears it. Set wins over a simultaneous clear.
- 0x18 SCRATCH: RW 32-bit.
- Other offsets inside the window read 0; writes are ignored.
- Requests outside the window: no state change; rdata loads 0 (en=1) as for an unmapped offset.

Read behaviour:
- Read-first. On any en=1 cycle, rdata loads the addressed register's value as held before that edge's update. Write cycles therefore also return the old value.
- en=0: rdata holds its previous value.

## Timing
- Reset values: rdata=0, led=0, timer_irq=0, TIMER=0, TIMER_CMP=0, CTRL=0, STATUS=0, SCRATCH=0, switch synchronizers=0.
- Reset asserted mid-operation clears everything immediately. An in-flight read returns 0.
- Read latency: 1 cycle. A request at edge N puts data on rdata after edge N, valid for sampling at edge N+1.
- Back-to-back requests are allowed every cycle. The block has no stall and no backpressure.
- Write effect is visible at edge N. A read of the same register issued at N+1 returns the new value.
- A TIMER read returns the value before that edge's increment.
- A switch change reaches the SWITCH register after 2 edges, so it is readable on the 3rd request.
- led is a direct register output, updated at the write edge.
- STATUS.match sets at the edge where equality is seen.
- timer_irq is registered from STATUS and CTRL, so it asserts one cycle after match sets.

## Test plan
- Reset, then read every offset 0x00-0x18 -> rdata = 0 each time; led = 0; timer_irq = 0.
- Write LED with we=4'b0011 and wdata=0x1234abcd, then read 0x00 -> led = 0xabcd and rdata = 0x0000abcd. A second write with we=4'b0001 and wdata=0xff -> 0xabff.
- TIMER=0xfffffffe, CTRL=1, then read TIMER every cycle -> sequence 0xfffffffe, 0xffffffff, 0x0, 0x1 (wrap). A write of 5 during counting -> next read returns 5.
- TIMER_CMP=10, TIMER=0, CTRL=3 -> STATUS.match sets when TIMER==10 and timer_irq rises one cycle later. Write STATUS=1 -> both clear. W1C issued in the exact match cycle -> match stays 1.
- Toggle sw from 0x00 to 0xa5 -> SWITCH reads 0x00 for 2 cycles, then 0xa5. A write to 0x04 has no effect.
- Read-first and window checks:
  - Write SCRATCH=0xdeadbeef -> that write cycle returns the old value 0.
  - Next read returns 0xdeadbeef.
  - Access at addr 0xbfb00018 -> rdata = 0 and SCRATCH unchanged.
  - Assert reset during a read -> rdata = 0.
